// File: rtl/sel_rgb_sched_pkg.sv
// Shared definitions for the sel_rgb_sched screen scheduler: state encodings,
// select/object/frame-counter widths and the title select pattern.
package sel_rgb_sched_pkg;

  localparam int unsigned SEL_W     = 17;
  localparam int unsigned TITLE_BIT = 16;
  localparam int unsigned OBJ_N     = 16;
  localparam int unsigned FCNT_W    = 5;

  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_GAME  = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam logic [SEL_W-1:0] TITLE_SEL = SEL_W'(1) << TITLE_BIT;

endpackage

// File: rtl/sel_rgb_sched_if.sv
// Pixel/button inputs and select/state outputs of sel_rgb_sched.
// master = stimulus side, slave = scheduler side.
interface sel_rgb_sched_if;
  import sel_rgb_sched_pkg::*;

  logic              pix_tick;
  logic              video_on;
  logic              frame_start;
  logic [OBJ_N-1:0]  obj_on;
  logic              title_on;
  logic              btn_start;
  logic              btn_pause;
  logic [SEL_W-1:0]  sel_rgb;
  logic [1:0]        state;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output pix_tick, video_on, frame_start, obj_on, title_on, btn_start, btn_pause,
    input  sel_rgb, state, frame_cnt
  );

  modport slave (
    input  pix_tick, video_on, frame_start, obj_on, title_on, btn_start, btn_pause,
    output sel_rgb, state, frame_cnt
  );

endinterface

// File: rtl/sel_rgb_sched_onehot_prio16.sv
// onehot_prio16: isolates the lowest-index set bit of obj_on and flags any hit.
module onehot_prio16
  import sel_rgb_sched_pkg::*;
(
  input  logic [OBJ_N-1:0] obj_on,
  output logic [OBJ_N-1:0] obj_oh,
  output logic             any_hit
);

  // x & -x keeps only the least significant set bit
  always_comb begin
    obj_oh  = obj_on & (~obj_on + OBJ_N'(1));
    any_hit = |obj_on;
  end

endmodule

// File: rtl/sel_rgb_sched.sv
// sel_rgb_sched: TITLE/GAME/PAUSE screen scheduler with frame-aligned state
// changes, frame counter and registered one-hot RGB multiplexer select.
// Optional macro SEL_RGB_TITLE_BLINK_EN blinks the title in TITLE state on
// frame_cnt[4] (16 frames on, 16 off).
module sel_rgb_sched
  import sel_rgb_sched_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  sel_rgb_sched_if.slave  bus
);

  state_e             state_q, state_d;
  state_e             tgt_q, tgt_d;
  logic               pend_q, pend_d;
  logic               start_q, start_d;
  logic               pause_q, pause_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [SEL_W-1:0]   sel_rgb_q, sel_rgb_d;

  logic [OBJ_N-1:0]   obj_oh;
  logic               any_hit;
  logic               start_rise, pause_rise;
  logic               req;
  state_e             req_tgt;
  logic               title_show;
  logic [SEL_W-1:0]   game_sel;

  onehot_prio16 u_prio (
    .obj_on  (bus.obj_on),
    .obj_oh  (obj_oh),
    .any_hit (any_hit)
  );

  // State, pending request, button history, frame counter and select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_TITLE;
      tgt_q       <= ST_TITLE;
      pend_q      <= 1'b0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      frame_cnt_q <= '0;
      sel_rgb_q   <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      pend_q      <= pend_d;
      start_q     <= start_d;
      pause_q     <= pause_d;
      frame_cnt_q <= frame_cnt_d;
      sel_rgb_q   <= sel_rgb_d;
    end
  end

  // Request decode, first-wins pending latch and frame-aligned state update.
  // The cycle that applies a pending request does not accept a new one.
  always_comb begin
    start_d     = bus.btn_start;
    pause_d     = bus.btn_pause;
    start_rise  = bus.btn_start & ~start_q;
    pause_rise  = bus.btn_pause & ~pause_q;
    state_d     = state_q;
    tgt_d       = tgt_q;
    pend_d      = pend_q;
    req         = 1'b0;
    req_tgt     = ST_TITLE;
    frame_cnt_d = bus.frame_start ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;

    case (state_q)
      ST_TITLE: begin
        if (start_rise) begin
          req     = 1'b1;
          req_tgt = ST_GAME;
        end
      end
      ST_GAME: begin
        if (pause_rise) begin
          req     = 1'b1;
          req_tgt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_rise) begin
          req     = 1'b1;
          req_tgt = ST_TITLE;
        end else if (pause_rise) begin
          req     = 1'b1;
          req_tgt = ST_GAME;
        end
      end
      default: ;
    endcase

    if (state_q != ST_TITLE && state_q != ST_GAME && state_q != ST_PAUSE) begin
      state_d = ST_TITLE;
      pend_d  = 1'b0;
    end else if (pend_q) begin
      if (bus.frame_start) begin
        state_d = tgt_q;
        pend_d  = 1'b0;
      end
    end else if (req) begin
      pend_d = 1'b1;
      tgt_d  = req_tgt;
    end
  end

  // Select computation, registered on pix_tick and held otherwise
  always_comb begin
`ifdef SEL_RGB_TITLE_BLINK_EN
    title_show = bus.title_on & ~frame_cnt_q[FCNT_W-1];
`else
    title_show = bus.title_on;
`endif
    game_sel  = any_hit ? {1'b0, obj_oh} : '0;
    sel_rgb_d = sel_rgb_q;
    if (bus.pix_tick) begin
      if (!bus.video_on) begin
        sel_rgb_d = '0;
      end else begin
        case (state_q)
          ST_TITLE: sel_rgb_d = title_show ? TITLE_SEL : '0;
          ST_GAME:  sel_rgb_d = game_sel;
          ST_PAUSE: sel_rgb_d = bus.title_on ? TITLE_SEL : game_sel;
          default:  sel_rgb_d = '0;
        endcase
      end
    end
  end

  assign bus.sel_rgb   = sel_rgb_q;
  assign bus.state     = state_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sel_rgb_sched.sv
// Self-checking bench for sel_rgb_sched: directed scenarios plus randomized
// stimulus against a behavioural screen/select model.
module tb_sel_rgb_sched;

`ifdef SEL_RGB_TITLE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  sel_rgb_sched_if bus();

  sel_rgb_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int err;

  // Behavioural model: 0=TITLE 1=GAME 2=PAUSE
  int        m_state;
  bit        m_pend;
  int        m_tgt;
  bit [4:0]  m_fcnt;
  bit [16:0] m_sel;
  bit        m_ps, m_pp;

  task automatic model_reset();
    m_state = 0; m_pend = 0; m_tgt = 0; m_fcnt = 0; m_sel = '0;
    m_ps = 0; m_pp = 0;
  endtask

  function automatic bit [16:0] lowest_obj(input bit [15:0] o);
    bit [16:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (o[i] && r == 0) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    bit sr, pr, has_req;
    int want;
    sr = bus.btn_start && !m_ps;
    pr = bus.btn_pause && !m_pp;
    has_req = 0; want = 0;
    if (m_state == 0 && sr) begin has_req = 1; want = 1; end
    if (m_state == 1 && pr) begin has_req = 1; want = 2; end
    if (m_state == 2 && sr) begin has_req = 1; want = 0; end
    else if (m_state == 2 && pr) begin has_req = 1; want = 1; end
    if (bus.pix_tick) begin
      if (!bus.video_on) m_sel = '0;
      else if (m_state == 0)
        m_sel = (bus.title_on && !(BLINK && m_fcnt[4])) ? 17'h10000 : 17'h0;
      else if (m_state == 2 && bus.title_on) m_sel = 17'h10000;
      else m_sel = lowest_obj(bus.obj_on);
    end
    if (m_pend) begin
      if (bus.frame_start) begin m_state = m_tgt; m_pend = 0; end
    end else if (has_req) begin
      m_pend = 1; m_tgt = want;
    end
    if (bus.frame_start) m_fcnt = m_fcnt + 1;
    m_ps = bus.btn_start;
    m_pp = bus.btn_pause;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pix(input bit [15:0] obj, input bit title, input bit vid);
    bus.obj_on = obj; bus.title_on = title; bus.video_on = vid; bus.pix_tick = 1'b1;
    tick();
    bus.pix_tick = 1'b0;
  endtask

  task automatic press(input bit s, input bit p);
    bus.btn_start = s; bus.btn_pause = p;
    tick();
    bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    vec++; if (bus.state !== 2'b00) begin err++; $display("FAIL reset_state got=%b exp=00", bus.state); end
    vec++; if (bus.sel_rgb !== 17'h0) begin err++; $display("FAIL reset_sel got=%h exp=00000", bus.sel_rgb); end
    vec++; if (bus.frame_cnt !== 5'd0) begin err++; $display("FAIL reset_fcnt got=%0d exp=0", bus.frame_cnt); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start_midframe();
    press(1'b1, 1'b0);
    repeat (4) tick();
    vec++; if (bus.state !== 2'b00) begin err++; $display("FAIL midframe_hold got=%b exp=00", bus.state); end
    frame();
    vec++; if (bus.state !== 2'b01) begin err++; $display("FAIL midframe_game got=%b exp=01", bus.state); end
    pix(16'h8000, 1'b1, 1'b1);
    vec++; if (bus.sel_rgb !== 17'h08000) begin err++; $display("FAIL game_obj15 got=%h exp=08000", bus.sel_rgb); end
  endtask

  task automatic test_game_sel();
    pix(16'h0028, 1'b0, 1'b1);
    vec++; if (bus.sel_rgb !== 17'h00008) begin err++; $display("FAIL game_0028 got=%h exp=00008", bus.sel_rgb); end
    pix(16'h0000, 1'b1, 1'b1);
    vec++; if (bus.sel_rgb !== 17'h00000) begin err++; $display("FAIL game_none got=%h exp=00000", bus.sel_rgb); end
    press(1'b1, 1'b0);
    frame();
    vec++; if (bus.state !== 2'b01) begin err++; $display("FAIL game_start_ign got=%b exp=01", bus.state); end
  endtask

  task automatic test_simul_rise();
    press(1'b1, 1'b1);
    vec++; if (bus.state !== 2'b01) begin err++; $display("FAIL simul_hold got=%b exp=01", bus.state); end
    frame();
    vec++; if (bus.state !== 2'b10) begin err++; $display("FAIL simul_pause got=%b exp=10", bus.state); end
    pix(16'h0001, 1'b1, 1'b1);
    vec++; if (bus.sel_rgb !== 17'h10000) begin err++; $display("FAIL pause_banner got=%h exp=10000", bus.sel_rgb); end
    pix(16'h0300, 1'b0, 1'b1);
    vec++; if (bus.sel_rgb !== 17'h00100) begin err++; $display("FAIL pause_obj got=%h exp=00100", bus.sel_rgb); end
  endtask

  task automatic test_first_wins();
    bus.btn_start = 1'b1; tick();
    bus.btn_start = 1'b0; bus.btn_pause = 1'b1; tick();
    bus.btn_pause = 1'b0; tick();
    frame();
    vec++; if (bus.state !== 2'b00) begin err++; $display("FAIL first_wins got=%b exp=00", bus.state); end
  endtask

  task automatic test_title_blink();
    bit [4:0] prev;
    bit [16:0] exp;
    pix(16'hFFFF, 1'b0, 1'b1);
    vec++; if (bus.sel_rgb !== 17'h0) begin err++; $display("FAIL title_no_obj got=%h exp=00000", bus.sel_rgb); end
    for (int f = 0; f < 34; f++) begin
      prev = m_fcnt;
      frame();
      vec++; if (bus.frame_cnt !== 5'(prev + 5'd1)) begin err++; $display("FAIL fcnt_inc got=%0d exp=%0d", bus.frame_cnt, 5'(prev + 5'd1)); end
      if (prev == 5'd31) begin
        vec++; if (bus.frame_cnt !== 5'd0) begin err++; $display("FAIL fcnt_wrap got=%0d exp=0", bus.frame_cnt); end
      end
      pix(16'($urandom), 1'b1, 1'b1);
      exp = (BLINK && m_fcnt[4]) ? 17'h0 : 17'h10000;
      vec++; if (bus.sel_rgb !== exp) begin err++; $display("FAIL title_blink fc=%0d got=%h exp=%h", m_fcnt, bus.sel_rgb, exp); end
    end
  endtask

  task automatic test_req_same_frame();
    bus.btn_start = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.btn_start = 1'b0; bus.frame_start = 1'b0;
    vec++; if (bus.state !== 2'b00) begin err++; $display("FAIL samefs_hold got=%b exp=00", bus.state); end
    tick();
    frame();
    vec++; if (bus.state !== 2'b01) begin err++; $display("FAIL samefs_apply got=%b exp=01", bus.state); end
  endtask

  task automatic test_video_off_hold();
    pix(16'hFFFF, 1'b1, 1'b0);
    vec++; if (bus.sel_rgb !== 17'h0) begin err++; $display("FAIL video_off got=%h exp=00000", bus.sel_rgb); end
    pix(16'h0004, 1'b0, 1'b1);
    vec++; if (bus.sel_rgb !== 17'h00004) begin err++; $display("FAIL pre_hold got=%h exp=00004", bus.sel_rgb); end
    for (int i = 0; i < 3; i++) begin
      bus.obj_on = 16'($urandom); bus.video_on = 1'($urandom);
      tick();
      vec++; if (bus.sel_rgb !== 17'h00004) begin err++; $display("FAIL hold c%0d got=%h exp=00004", i, bus.sel_rgb); end
    end
  endtask

  task automatic test_async_reset();
    pix(16'h0040, 1'b0, 1'b1);
    press(1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    vec++; if (bus.sel_rgb !== 17'h0) begin err++; $display("FAIL async_sel got=%h exp=00000", bus.sel_rgb); end
    vec++; if (bus.state !== 2'b00) begin err++; $display("FAIL async_state got=%b exp=00", bus.state); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    vec++; if (bus.state !== 2'b00) begin err++; $display("FAIL post_rst_hold got=%b exp=00", bus.state); end
    frame();
    vec++; if (bus.state !== 2'b00) begin err++; $display("FAIL pend_discard got=%b exp=00", bus.state); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.pix_tick    = ($urandom_range(0, 3) != 0);
      bus.video_on    = ($urandom_range(0, 7) != 0);
      bus.frame_start = ($urandom_range(0, 15) == 0);
      bus.obj_on      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      bus.title_on    = 1'($urandom);
      if ($urandom_range(0, 5) == 0) bus.btn_start = ~bus.btn_start;
      if ($urandom_range(0, 5) == 0) bus.btn_pause = ~bus.btn_pause;
      tick();
      vec++;
      if (bus.sel_rgb !== m_sel || bus.state !== 2'(m_state) || bus.frame_cnt !== m_fcnt) begin
        err++;
        $display("FAIL random i=%0d sel=%h/%h state=%b/%b fcnt=%0d/%0d (got/exp)",
                 i, bus.sel_rgb, m_sel, bus.state, 2'(m_state), bus.frame_cnt, m_fcnt);
      end
    end
    bus.btn_start = 1'b0; bus.btn_pause = 1'b0; bus.frame_start = 1'b0; bus.pix_tick = 1'b0;
  endtask

  initial begin
    vec = 0; err = 0;
    rst_n = 1'b0;
    bus.pix_tick = 0; bus.video_on = 0; bus.frame_start = 0; bus.obj_on = '0;
    bus.title_on = 0; bus.btn_start = 0; bus.btn_pause = 0;
    model_reset();
    #2;
    test_reset();
    test_start_midframe();
    test_game_sel();
    test_simul_rise();
    test_first_wins();
    test_title_blink();
    test_req_same_frame();
    test_video_off_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
